// File: rtl/libiu_pkg.sv
// Shared IU trace types: clock bundle, commit-trace record layout, flag bit indices.
// Parameter defaults here define the record width used by every trace block.
package libiu;

    localparam int TRACE_DEPTH = 16;
    localparam int TRACE_TIDW  = 6;

    // Bit positions inside the 5-bit commit flag vector
    localparam int FLG_ICMISS = 0;
    localparam int FLG_UCMODE = 1;
    localparam int FLG_DMA    = 2;
    localparam int FLG_ANNUL  = 3;
    localparam int FLG_REPLAY = 4;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        longint unsigned       ctime;
        logic [TRACE_TIDW-1:0] tid;
        logic [31:0]           pc;
        logic [31:0]           inst;
        logic                  replay;
        logic                  annul;
        logic                  dma_mode;
        logic                  ucmode;
        logic [7:0]            upc;
        logic                  gap;
    } trace_rec_type;

endpackage

// File: rtl/inst_trace_fifo_mem.sv
// Trace record storage: one write port, one registered read port, write-first on collision.
// Latency: read data appears the cycle after the address is presented.
// Backpressure: none; the owner decides when to write.
module trace_fifo_mem
    import libiu::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  trace_rec_type wr_data,
    input  logic [AW-1:0] rd_addr,
    output trace_rec_type rd_data
);

    trace_rec_type mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // A write to the upcoming head only happens when the queue drains to it,
        // so forwarding the write data keeps the head register current.
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_trace_fifo.sv
// Commit-trace capture FIFO with cycle timestamps; optional per-thread filter via INST_TRACE_FILTER_EN.
// Latency: a record captured in cycle N is visible at the output in cycle N+1.
// Backpressure: never stalls the pipeline; captures into a full queue are dropped and counted.
module inst_trace_fifo
    import libiu::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int TIDW  = TRACE_TIDW,
    parameter int CNTW  = 16
) (
    input  iu_clk_type                 gclk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [TIDW-1:0]            in_tid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_inst,
    input  logic [4:0]                 in_flags,
    input  logic [7:0]                 in_upc,
    input  logic [(2**TIDW)-1:0]       thread_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output trace_rec_type              out_rec,
    output logic [$clog2(DEPTH):0]     level,
    output logic [CNTW-1:0]            drop_cnt,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic          clk;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_ptr_nxt;
    logic [63:0]   cycle_ctr;
    logic          gap_flag;
    logic          capture;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    trace_rec_type wr_rec;

    assign clk = gclk.clk;

`ifdef INST_TRACE_FILTER_EN
    assign capture = in_valid & ~in_flags[FLG_ICMISS] & thread_mask[in_tid];
`else
    logic unused_thread_mask;
    assign unused_thread_mask = ^thread_mask;
    assign capture = in_valid & ~in_flags[FLG_ICMISS];
`endif

    assign out_valid  = (level != '0);
    assign full       = (level == LW'(DEPTH));
    assign pop        = out_valid & out_ready;
    assign push       = capture & (~full | pop);
    assign drop       = capture & full & ~pop;
    assign rd_ptr_nxt = rd_ptr + AW'(pop);

    always_comb begin
        wr_rec          = '0;
        wr_rec.ctime    = cycle_ctr;
        wr_rec.tid      = TRACE_TIDW'(in_tid);
        wr_rec.pc       = in_pc;
        wr_rec.inst     = in_inst;
        wr_rec.replay   = in_flags[FLG_REPLAY];
        wr_rec.annul    = in_flags[FLG_ANNUL];
        wr_rec.dma_mode = in_flags[FLG_DMA];
        wr_rec.ucmode   = in_flags[FLG_UCMODE];
        wr_rec.upc      = in_upc;
        wr_rec.gap      = gap_flag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            drop_cnt  <= '0;
            overflow  <= 1'b0;
            cycle_ctr <= '0;
            gap_flag  <= 1'b0;
        end else begin
            cycle_ctr <= cycle_ctr + 64'd1;
            rd_ptr    <= rd_ptr_nxt;
            if (push) begin
                wr_ptr   <= wr_ptr + AW'(1);
                gap_flag <= 1'b0;
            end
            level <= level + LW'(push) - LW'(pop);
            if (drop) begin
                overflow <= 1'b1;
                gap_flag <= 1'b1;
                if (drop_cnt != '1) begin
                    drop_cnt <= drop_cnt + CNTW'(1);
                end
            end
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_rec),
        .rd_addr (rd_ptr_nxt),
        .rd_data (out_rec)
    );

endmodule

// File: tb/tb_inst_trace_fifo.sv
// Directed bench for inst_trace_fifo: ordering, timestamps, overflow/gap, icmiss, reset, filter.
module tb_inst_trace_fifo;
    import libiu::*;

    localparam int DEPTH = 16;
    localparam int TIDW  = 6;
    localparam int CNTW  = 16;

    iu_clk_type           gclk;
    logic                 rst;
    logic                 in_valid;
    logic [TIDW-1:0]      in_tid;
    logic [31:0]          in_pc;
    logic [31:0]          in_inst;
    logic [4:0]           in_flags;
    logic [7:0]           in_upc;
    logic [(2**TIDW)-1:0] thread_mask;
    logic                 out_valid;
    logic                 out_ready;
    trace_rec_type        out_rec;
    logic [4:0]           level;
    logic [CNTW-1:0]      drop_cnt;
    logic                 overflow;

    int total = 0;
    int bad   = 0;

    inst_trace_fifo #(.DEPTH(DEPTH), .TIDW(TIDW), .CNTW(CNTW)) dut (
        .gclk        (gclk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_tid      (in_tid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_flags    (in_flags),
        .in_upc      (in_upc),
        .thread_mask (thread_mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rec     (out_rec),
        .level       (level),
        .drop_cnt    (drop_cnt),
        .overflow    (overflow)
    );

    initial begin
        gclk.clk = 1'b0;
        forever #5 gclk.clk = ~gclk.clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge gclk.clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [TIDW-1:0] tid, input logic [31:0] pc,
                         input logic [4:0] flags);
        in_valid = v;
        in_tid   = tid;
        in_pc    = pc;
        in_inst  = ~pc;
        in_flags = flags;
        in_upc   = pc[9:2];
    endtask

    initial begin
        rst         = 1'b1;
        out_ready   = 1'b0;
        thread_mask = '0;
        drive(1'b0, '0, '0, '0);
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // Three back-to-back captures with a ready consumer; counter is 0 at first capture
        out_ready = 1'b1;
        drive(1'b1, 6'd1, 32'h4000_0000, 5'b00000);
        step();
        chk("s1_v0", 64'(out_valid), 64'd1);
        chk("s1_tid0", 64'(out_rec.tid), 64'd1);
        chk("s1_ct0", out_rec.ctime, 64'd0);
        chk("s1_inst0", 64'(out_rec.inst), 64'hBFFF_FFFF);
        drive(1'b1, 6'd2, 32'h4000_0004, 5'b00000);
        step();
        chk("s1_tid1", 64'(out_rec.tid), 64'd2);
        chk("s1_ct1", out_rec.ctime, 64'd1);
        chk("s1_pc1", 64'(out_rec.pc), 64'h4000_0004);
        drive(1'b1, 6'd3, 32'h4000_0008, 5'b10110);
        step();
        chk("s1_tid2", 64'(out_rec.tid), 64'd3);
        chk("s1_ct2", out_rec.ctime, 64'd2);
        chk("s1_gap2", 64'(out_rec.gap), 64'd0);
        chk("s1_flags2", 64'({out_rec.replay, out_rec.annul, out_rec.dma_mode, out_rec.ucmode}),
            64'b1011);
        chk("s1_upc2", 64'(out_rec.upc), 64'h02);
        chk("s1_lvl2", 64'(level), 64'd1);
        drive(1'b0, '0, '0, '0);
        step();
        chk("s1_empty", 64'(out_valid), 64'd0);

        // Overflow: DEPTH+2 captures with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            drive(1'b1, 6'(i), 32'h1000 + 32'(4 * i), 5'b00000);
            step();
        end
        drive(1'b0, '0, '0, '0);
        chk("s2_level", 64'(level), 64'd16);
        chk("s2_drop", 64'(drop_cnt), 64'd2);
        chk("s2_ovf", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("s2_drain_pc", 64'(out_rec.pc), 64'h1000 + 64'(4 * i));
            chk("s2_drain_gap", 64'(out_rec.gap), 64'd0);
            step();
        end
        chk("s2_drained", 64'(level), 64'd0);
        out_ready = 1'b0;
        drive(1'b1, 6'd5, 32'h2000, 5'b00000);
        step();
        chk("s2_gap1", 64'(out_rec.gap), 64'd1);
        drive(1'b1, 6'd6, 32'h2004, 5'b00000);
        step();
        drive(1'b0, '0, '0, '0);
        step();
        chk("s2_stable", 64'(out_rec.pc), 64'h2000);
        out_ready = 1'b1;
        step();
        chk("s2_pc_next", 64'(out_rec.pc), 64'h2004);
        chk("s2_gap0", 64'(out_rec.gap), 64'd0);
        step();
        chk("s2_empty", 64'(out_valid), 64'd0);

        // Full queue with simultaneous capture and pop
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 6'd9, 32'h3000 + 32'(4 * i), 5'b00000);
            step();
        end
        chk("s3_full", 64'(level), 64'd16);
        out_ready = 1'b1;
        drive(1'b1, 6'd10, 32'h3100, 5'b00000);
        step();
        drive(1'b0, '0, '0, '0);
        chk("s3_level", 64'(level), 64'd16);
        chk("s3_drop", 64'(drop_cnt), 64'd2);
        for (int i = 0; i < DEPTH - 1; i++) begin
            chk("s3_drain_pc", 64'(out_rec.pc), 64'h3004 + 64'(4 * i));
            step();
        end
        chk("s3_tail_pc", 64'(out_rec.pc), 64'h3100);
        chk("s3_tail_tid", 64'(out_rec.tid), 64'd10);
        step();
        chk("s3_empty", 64'(level), 64'd0);

        // Icmiss records are never queued
        drive(1'b1, 6'd1, 32'h100, 5'b00001);
        step();
        drive(1'b0, '0, '0, '0);
        chk("s4_level", 64'(level), 64'd0);
        chk("s4_valid", 64'(out_valid), 64'd0);
        chk("s4_drop", 64'(drop_cnt), 64'd2);

        // Reset mid-drain with five entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 6'd4, 32'h5000 + 32'(4 * i), 5'b00000);
            step();
        end
        drive(1'b0, '0, '0, '0);
        chk("s5_level5", 64'(level), 64'd5);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s5_valid", 64'(out_valid), 64'd0);
        chk("s5_level", 64'(level), 64'd0);
        chk("s5_drop", 64'(drop_cnt), 64'd0);
        chk("s5_ovf", 64'(overflow), 64'd0);
        step();
        out_ready = 1'b0;
        drive(1'b1, 6'd7, 32'h6000, 5'b00000);
        step();
        drive(1'b0, '0, '0, '0);
        chk("s5_ctime", out_rec.ctime, 64'd1);
        chk("s5_pc", 64'(out_rec.pc), 64'h6000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Thread filter: only tid 2 enabled
        thread_mask = 64'h4;
        for (int t = 1; t <= 3; t++) begin
            drive(1'b1, 6'(t), 32'h7000 + 32'(4 * t), 5'b00000);
            step();
        end
        drive(1'b0, '0, '0, '0);
`ifdef INST_TRACE_FILTER_EN
        chk("s6_level", 64'(level), 64'd1);
        chk("s6_tid", 64'(out_rec.tid), 64'd2);
`else
        chk("s6_level", 64'(level), 64'd3);
        chk("s6_tid", 64'(out_rec.tid), 64'd1);
`endif
        chk("s6_drop", 64'(drop_cnt), 64'd0);
        chk("s6_gap", 64'(out_rec.gap), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_trace_fifo.md
Name: inst_trace_fifo

Overview:
- Synthesizable commit-trace capture buffer that sits between the exception/commit (XC) stage and the simulation trace consumer.
- Each cycle it accepts at most one commit record (thread id, PC, instruction, status flags), timestamps it with a free-running cycle counter, and queues it.
- Records drain through a valid/ready interface, so a slow consumer (DPI disassembler or host DMA) never back-pressures the pipeline.
- Overflow drops records and counts them; the pipeline is never stalled.

Parameters:
- DEPTH, 16, number of record entries; power of two, 2..256
- TIDW, 6, thread id width
- CNTW, 16, width of the dropped-record counter

Ports:
- gclk  input  iu_clk_type  clock bundle; all logic on posedge gclk.clk
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  commit record present this cycle
- in_tid  input  TIDW  thread id
- in_pc  input  32  PC
- in_inst  input  32  instruction word
- in_flags  input  5  {replay, annul, dma_mode, ucmode, icmiss}
- in_upc  input  8  microcode PC
- thread_mask  input  2**TIDW  per-thread trace enable (used only with the optional feature)
- out_valid  output  1  head record available
- out_ready  input  1  consumer accepts head
- out_rec  output  trace_rec_type  head record
- level  output  $clog2(DEPTH)+1  current occupancy
- drop_cnt  output  CNTW  saturating count of dropped records
- overflow  output  1  sticky; set on first drop

Behaviour:
- Reset (rst=1 at posedge): rd/wr pointers=0, level=0, out_valid=0, drop_cnt=0, overflow=0, cycle counter=0, gap flag=0. Reset mid-drain discards all queued records; out_rec contents are don't-care while out_valid=0.
- Cycle counter: 64-bit, increments every non-reset cycle, wraps to 0 after all-ones.
- Capture condition: in_valid & ~in_flags.icmiss (& mask, see Optional Feature). Icmiss records are never queued or counted.
- Push: the record stores tid, pc, inst, flags, upc, the cycle counter value of the capture cycle, and gap=gap_flag. gap_flag then clears.
- Latency: a record captured in cycle N gives out_valid=1 in cycle N+1 at the earliest. There is no same-cycle bypass.
- Pop: occurs when out_valid & out_ready. The next entry appears in the following cycle, giving sustained 1 record/cycle throughput.
- Full (level==DEPTH) with capture and no pop: record dropped. drop_cnt increments, saturating at all-ones. overflow=1 (sticky until reset). gap_flag=1.
- Full with simultaneous capture and pop: both succeed, no drop, level unchanged.
- Empty with capture: level goes 0 to 1. out_ready is ignored while out_valid=0.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. Full/empty are derived from level, not from pointer equality.
- out_rec is registered from storage; it is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: INST_TRACE_FILTER_EN.
- Defined: capture additionally requires thread_mask[in_tid]=1. Masked records are silently discarded; they do not count as drops and do not set gap.
- Undefined: thread_mask is unconnected internally and every thread is traced.

Decomposition:
- Shared package libiu holds:
  - typedef trace_rec_type {longint unsigned ctime; tid; pc; inst; replay, annul, dma_mode, ucmode; upc; gap}
  - trace flag bit-index constants
  - default DEPTH constant
- One sub-module, trace_fifo_mem: a DEPTH x $bits(trace_rec_type) dual-port storage with a single write port and a registered read port. Pointer, level and drop logic stay in inst_trace_fifo.

Test Plan:
- Reset, then 3 captures (tid 1,2,3; pc 0x40000000/04/08) with out_ready=1 -> records emerge in order one cycle after each capture; ctime values differ by 1; gap=0.
- out_ready=0, DEPTH+2 captures -> level=16, drop_cnt=2, overflow=1. Then assert out_ready -> 16 records drain in order; next capture has gap=1 and the one after has gap=0.
- Full FIFO, capture and pop in the same cycle -> level stays 16, drop_cnt unchanged, new record later appears at the tail.
- Capture with icmiss=1 (pc 0x100) -> no push, level unchanged, drop_cnt unchanged.
- Assert rst while level=5 mid-drain -> next cycle out_valid=0, level=0, drop_cnt=0; first post-reset record has ctime=1.
- With INST_TRACE_FILTER_EN, thread_mask=0x...04, captures for tids 1, 2 and 3 -> only tid 2 queued; drop_cnt=0.
